// File: rtl/hcsr04_echo_ranger.sv
// HC-SR04 initiator: issues a trigger pulse, times the echo in microsecond ticks,
// and enforces the sensor re-trigger interval before accepting another request.
module hcsr04_echo_ranger #(
    parameter int TICK_DIV   = 50,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 38000,
    parameter int HOLDOFF_US = 60000,
    parameter int CNT_W      = 16
) (
    input  logic             cclk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             echo,
    output logic             trig,
    output logic             busy,
    output logic [CNT_W-1:0] dist_us,
    output logic             valid,
    output logic             timeout
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRESC_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_US - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_US - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLDOFF_US - 1);
    localparam logic [CNT_W-1:0] HOLD_END     = CNT_W'(HOLDOFF_US);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

    state_t state_reg, state_next;

    logic             echo_meta_reg, echo_sync_reg, echo_prev_reg;
    logic [PRE_W-1:0] presc_reg, hold_presc_reg;
    logic [CNT_W-1:0] us_cnt_reg, hold_cnt_reg, dist_reg;
    logic             valid_reg, timeout_reg;

    logic             echo_rise, echo_fall;
    logic             tick, hold_tick;
    logic [CNT_W-1:0] us_inc, hold_inc;
    logic             us_timeout, hold_done;
    logic             meas_done, meas_abort;

    assign echo_rise  = echo_sync_reg & ~echo_prev_reg;
    assign echo_fall  = ~echo_sync_reg & echo_prev_reg;
    assign tick       = (presc_reg == PRESC_LAST);
    assign hold_tick  = (hold_presc_reg == PRESC_LAST);
    assign us_inc     = (us_cnt_reg == '1) ? us_cnt_reg : us_cnt_reg + CNT_W'(1);
    assign hold_inc   = (hold_cnt_reg == '1) ? hold_cnt_reg : hold_cnt_reg + CNT_W'(1);
    assign us_timeout = tick && (us_cnt_reg == TIMEOUT_LAST);
    assign hold_done  = (hold_tick && (hold_cnt_reg == HOLD_LAST)) || (hold_cnt_reg >= HOLD_END);

    always_ff @(posedge cclk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (start) state_next = TRIG;
            TRIG:      if (tick && (us_cnt_reg == TRIG_LAST)) state_next = WAIT_RISE;
            WAIT_RISE: if (echo_rise || us_timeout) state_next = echo_rise ? MEASURE : HOLDOFF;
            MEASURE:   if (echo_fall || us_timeout) state_next = HOLDOFF;
            HOLDOFF:   if (hold_done) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // A fall landing on the timeout cycle still counts as a good measurement.
    always_comb begin
        trig       = (state_reg == TRIG);
        busy       = (state_reg != IDLE);
        meas_done  = (state_reg == MEASURE) && echo_fall;
        meas_abort = ((state_reg == WAIT_RISE) && !echo_rise && us_timeout) ||
                     ((state_reg == MEASURE) && !echo_fall && us_timeout);
    end

    always_ff @(posedge cclk or negedge clr_n) begin
        if (!clr_n) begin
            echo_meta_reg  <= 1'b0;
            echo_sync_reg  <= 1'b0;
            echo_prev_reg  <= 1'b0;
            presc_reg      <= '0;
            us_cnt_reg     <= '0;
            hold_presc_reg <= '0;
            hold_cnt_reg   <= '0;
            dist_reg       <= '0;
            valid_reg      <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            echo_meta_reg <= echo;
            echo_sync_reg <= echo_meta_reg;
            echo_prev_reg <= echo_sync_reg;

            if (state_next != state_reg) begin
                presc_reg  <= '0;
                us_cnt_reg <= '0;
            end else begin
                presc_reg <= tick ? '0 : presc_reg + PRE_W'(1);
                if (tick) us_cnt_reg <= us_inc;
            end

            // Holdoff timing spans the whole transaction, starting at trigger entry.
            if (state_reg == IDLE) begin
                hold_presc_reg <= '0;
                hold_cnt_reg   <= '0;
            end else begin
                hold_presc_reg <= hold_tick ? '0 : hold_presc_reg + PRE_W'(1);
                if (hold_tick) hold_cnt_reg <= hold_inc;
            end

            valid_reg   <= meas_done;
            timeout_reg <= meas_abort;
            if (meas_done) dist_reg <= tick ? us_inc : us_cnt_reg;
        end
    end

    assign dist_us = dist_reg;
    assign valid   = valid_reg;
    assign timeout = timeout_reg;

endmodule
